// File: rtl/rv_decode_pkg.sv
// Shared decode definitions: RV32 base opcodes, immediate format select, destination-write helper.
// Imported by imm_gen and decode_stage.
package rv_decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
        return (rd != 5'd0) && (op != OP_STORE) && (op != OP_BRANCH);
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: classifies an RV32 instruction word by immediate format and builds the sign-extended immediate.
// Purely combinational; R-type and unknown opcodes yield zero.
module imm_gen
    import rv_decode_pkg::*;
(
    input  logic [31:0] i_insn,
    output imm_type_e   o_imm_type,
    output logic [31:0] o_imm
);

    always_comb begin
        o_imm_type = IMM_NONE;
        case (i_insn[6:0])
            OP_OP:                          o_imm_type = IMM_R;
            OP_OP_IMM, OP_LOAD, OP_JALR:    o_imm_type = IMM_I;
            OP_STORE:                       o_imm_type = IMM_S;
            OP_BRANCH:                      o_imm_type = IMM_B;
            OP_LUI, OP_AUIPC:               o_imm_type = IMM_U;
            OP_JAL:                         o_imm_type = IMM_J;
            default:                        o_imm_type = IMM_NONE;
        endcase
    end

    always_comb begin
        o_imm = '0;
        case (o_imm_type)
            IMM_I: o_imm = {{20{i_insn[31]}}, i_insn[31:20]};
            IMM_S: o_imm = {{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]};
            IMM_B: o_imm = {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
            IMM_U: o_imm = {i_insn[31:12], 12'b0};
            IMM_J: o_imm = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes fetched instructions into a registered ID/EX bundle (1 cycle), stalling RAW hazards via a
// per-register outstanding-write scoreboard. Optional writeback bypass enabled by DECODE_WB_BYPASS_EN.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SB_BITS = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            f_valid,
    output logic            f_ready,
    input  logic [31:0]     f_pc,
    input  logic [31:0]     f_insn,
    output logic [31:0]     addr_rs1,
    output logic [31:0]     addr_rs2,
    input  logic [XLEN-1:0] data_rs1,
    input  logic [XLEN-1:0] data_rs2,
    input  logic            wb_valid,
    input  logic [4:0]      wb_addr_rd,
    input  logic [XLEN-1:0] wb_data_rd,
    input  logic            flush,
    output logic            x_valid,
    input  logic            x_ready,
    output logic [31:0]     x_pc,
    output logic [31:0]     x_insn,
    output logic [XLEN-1:0] x_rs1_data,
    output logic [XLEN-1:0] x_rs2_data,
    output logic [31:0]     x_imm,
    output logic [4:0]      x_rd,
    output logic            x_reg_write,
    output logic            x_is_load
);

    localparam logic [SB_BITS-1:0] SB_MAX = '1;
    localparam logic [SB_BITS-1:0] SB_ONE = SB_BITS'(1);

    logic [SB_BITS-1:0] r_sb_cnt [32];
    logic [SB_BITS-1:0] w_sb_nxt [32];
    logic [31:0]        w_sb_uflow;

    logic            r_x_valid;
    logic [31:0]     r_x_pc;
    logic [31:0]     r_x_insn;
    logic [XLEN-1:0] r_x_rs1_data;
    logic [XLEN-1:0] r_x_rs2_data;
    logic [31:0]     r_x_imm;
    logic [4:0]      r_x_rd;
    logic            r_x_reg_write;
    logic            r_x_is_load;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    imm_type_e       w_imm_type;
    logic [31:0]     w_imm;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_reg_write;
    logic            w_rs1_haz;
    logic            w_rs2_haz;
    logic            w_rd_haz;
    logic            w_hazard;
    logic            w_load_en;
    logic            w_f_ready;
    logic            w_accept;
    logic            w_inc_en;
    logic            w_wb_dec;
    logic            w_kill_dec;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign w_opcode = f_insn[6:0];
    assign w_rd     = f_insn[11:7];
    assign w_rs1    = f_insn[19:15];
    assign w_rs2    = f_insn[24:20];

    assign addr_rs1 = {27'b0, w_rs1};
    assign addr_rs2 = {27'b0, w_rs2};

    imm_gen u_imm_gen (
        .i_insn     (f_insn),
        .o_imm_type (w_imm_type),
        .o_imm      (w_imm)
    );

    // Format type doubles as the operand-usage decode: U/J have no rs1, only R/S/B read rs2.
    assign w_rs1_used  = (w_rs1 != 5'd0) && (w_imm_type != IMM_U) && (w_imm_type != IMM_J);
    assign w_rs2_used  = (w_rs2 != 5'd0) &&
                         ((w_imm_type == IMM_R) || (w_imm_type == IMM_S) || (w_imm_type == IMM_B));
    assign w_reg_write = writes_rd(w_opcode, w_rd);

`ifdef DECODE_WB_BYPASS_EN
    logic w_wb_hit_rs1;
    logic w_wb_hit_rs2;

    assign w_wb_hit_rs1 = wb_valid && (wb_addr_rd == w_rs1);
    assign w_wb_hit_rs2 = wb_valid && (wb_addr_rd == w_rs2);

    // A retiring last writer satisfies the read in the same cycle.
    assign w_rs1_haz = w_rs1_used && (r_sb_cnt[w_rs1] != '0) &&
                       !(w_wb_hit_rs1 && (r_sb_cnt[w_rs1] == SB_ONE));
    assign w_rs2_haz = w_rs2_used && (r_sb_cnt[w_rs2] != '0) &&
                       !(w_wb_hit_rs2 && (r_sb_cnt[w_rs2] == SB_ONE));

    assign w_rs1_data = (w_rs1 == 5'd0) ? '0 : (w_wb_hit_rs1 ? wb_data_rd : data_rs1);
    assign w_rs2_data = (w_rs2 == 5'd0) ? '0 : (w_wb_hit_rs2 ? wb_data_rd : data_rs2);
`else
    logic w_unused_wb_data;

    assign w_unused_wb_data = ^{wb_data_rd, SB_ONE};
    assign w_rs1_haz  = w_rs1_used && (r_sb_cnt[w_rs1] != '0);
    assign w_rs2_haz  = w_rs2_used && (r_sb_cnt[w_rs2] != '0);
    assign w_rs1_data = (w_rs1 == 5'd0) ? '0 : data_rs1;
    assign w_rs2_data = (w_rs2 == 5'd0) ? '0 : data_rs2;
`endif

    assign w_rd_haz  = w_reg_write && (r_sb_cnt[w_rd] == SB_MAX);
    assign w_hazard  = w_rs1_haz || w_rs2_haz || w_rd_haz;
    assign w_load_en = !r_x_valid || x_ready;
    assign w_f_ready = w_load_en && !w_hazard && !flush;
    assign w_accept  = f_valid && w_f_ready;
    assign f_ready   = w_f_ready;

    assign w_inc_en   = w_accept && w_reg_write;
    assign w_wb_dec   = wb_valid && (wb_addr_rd != 5'd0);
    // A flushed writer still held here never reaches writeback, so its count is returned now.
    assign w_kill_dec = flush && r_x_valid && r_x_reg_write && !x_ready;

    for (genvar g = 0; g < 32; g++) begin : g_sb
        logic               w_inc;
        logic               w_dec_wb;
        logic               w_dec_kill;
        logic [SB_BITS:0]   w_sum;
        logic [SB_BITS:0]   w_dec;

        assign w_inc      = w_inc_en   && (w_rd       == 5'(g));
        assign w_dec_wb   = w_wb_dec   && (wb_addr_rd == 5'(g));
        assign w_dec_kill = w_kill_dec && (r_x_rd     == 5'(g));
        assign w_sum      = {1'b0, r_sb_cnt[g]} + (SB_BITS+1)'(w_inc);
        assign w_dec      = (SB_BITS+1)'(w_dec_wb) + (SB_BITS+1)'(w_dec_kill);
        assign w_sb_uflow[g] = (w_sum < w_dec);
        assign w_sb_nxt[g]   = w_sb_uflow[g] ? '0 : SB_BITS'(w_sum - w_dec);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_sb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++) r_sb_cnt[i] <= w_sb_nxt[i];
        end
    end

    a_sb_no_underflow: assert property (@(posedge clock) disable iff (reset) w_sb_uflow == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x_valid     <= 1'b0;
            r_x_pc        <= '0;
            r_x_insn      <= '0;
            r_x_rs1_data  <= '0;
            r_x_rs2_data  <= '0;
            r_x_imm       <= '0;
            r_x_rd        <= '0;
            r_x_reg_write <= 1'b0;
            r_x_is_load   <= 1'b0;
        end else begin
            if (flush)          r_x_valid <= 1'b0;
            else if (w_load_en) r_x_valid <= w_accept;

            if (w_accept) begin
                r_x_pc        <= f_pc;
                r_x_insn      <= f_insn;
                r_x_rs1_data  <= w_rs1_data;
                r_x_rs2_data  <= w_rs2_data;
                r_x_imm       <= w_imm;
                r_x_rd        <= w_rd;
                r_x_reg_write <= w_reg_write;
                r_x_is_load   <= (w_opcode == OP_LOAD);
            end
        end
    end

    assign x_valid     = r_x_valid;
    assign x_pc        = r_x_pc;
    assign x_insn      = r_x_insn;
    assign x_rs1_data  = r_x_rs1_data;
    assign x_rs2_data  = r_x_rs2_data;
    assign x_imm       = r_x_imm;
    assign x_rd        = r_x_rd;
    assign x_reg_write = r_x_reg_write;
    assign x_is_load   = r_x_is_load;

endmodule
